// File: rtl/kws_event_reporter.sv
// Keyword-spotting event reporter.
// Samples classifier results, confirms a keyword over consecutive results, applies a
// hold-off, and queues confirmed events (keyword + result-count timestamp) in a small
// first-word-fall-through FIFO drained via valid/ready. irq mirrors evt_valid.
// Optional build macro: KWS_MULTI_HIT_REJECT_EN (multi-bit results treated as "none" and
// counted in multi_hit_count).
module kws_event_reporter #(
  parameter int unsigned NUM_KEYWORDS    = 10,
  parameter int unsigned KW_IDX_BITS     = 4,
  parameter int unsigned CONFIRM_COUNT   = 3,
  parameter int unsigned HOLDOFF_RESULTS = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned TS_BITS         = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_KEYWORDS-1:0]       kws_result,
  input  logic                          kws_valid,
  input  logic                          enable,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [KW_IDX_BITS-1:0]        evt_keyword,
  output logic [TS_BITS-1:0]            evt_timestamp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          irq,
  output logic                          overflow,
`ifdef KWS_MULTI_HIT_REJECT_EN
  output logic [7:0]                    multi_hit_count,
`endif
  input  logic                          clear_overflow
);

  localparam int unsigned PtrBits  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlBits  = PtrBits + 1;
  localparam int unsigned RunBits  = 4;
  localparam int unsigned HoldBits = (HOLDOFF_RESULTS > 0) ? $clog2(HOLDOFF_RESULTS + 1) : 1;

  typedef enum logic [1:0] {StIdle, StTrack, StHoldoff} state_e;

  // ---------------------------------------------------------------------------------------
  // Result decode
  // ---------------------------------------------------------------------------------------
  logic [KW_IDX_BITS-1:0] dec_idx;
  logic                   any_hit;
  logic                   det;
`ifdef KWS_MULTI_HIT_REJECT_EN
  logic                   multi;
`endif

  // Lowest set bit wins; scanning downward lets the lowest index overwrite higher ones.
  always_comb begin
    dec_idx = '0;
    any_hit = 1'b0;
    for (int i = int'(NUM_KEYWORDS) - 1; i >= 0; i--) begin
      if (kws_result[i]) begin
        dec_idx = KW_IDX_BITS'(i);
        any_hit = 1'b1;
      end
    end
`ifdef KWS_MULTI_HIT_REJECT_EN
    multi = |(kws_result & (kws_result - NUM_KEYWORDS'(1)));
    det   = any_hit && !multi;
`else
    det   = any_hit;
`endif
  end

  // ---------------------------------------------------------------------------------------
  // Result-count timestamp
  // ---------------------------------------------------------------------------------------
  logic [TS_BITS-1:0] ts_q;

  // Counts every result regardless of enable; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else if (kws_valid) begin
      ts_q <= ts_q + TS_BITS'(1);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Confirmation state machine
  // ---------------------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [KW_IDX_BITS-1:0] cand_q, cand_d;
  logic [RunBits-1:0]     run_q, run_d;
  logic [HoldBits-1:0]    hold_q, hold_d;
  logic                   confirm;

  localparam state_e AfterConfirm = (HOLDOFF_RESULTS == 0) ? StIdle : StHoldoff;

  // State, candidate, run and hold-off registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cand_q  <= '0;
      run_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; only kws_valid cycles advance, enable low overrides everything.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    hold_d  = hold_q;
    confirm = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      cand_d  = '0;
      run_d   = '0;
      hold_d  = '0;
    end else if (kws_valid) begin
      unique case (state_q)
        StIdle: begin
          if (det) begin
            cand_d = dec_idx;
            if (CONFIRM_COUNT == 1) begin
              confirm = 1'b1;
              run_d   = '0;
              state_d = AfterConfirm;
              hold_d  = HoldBits'(HOLDOFF_RESULTS);
            end else begin
              run_d   = RunBits'(1);
              state_d = StTrack;
            end
          end
        end
        StTrack: begin
          if (!det) begin
            state_d = StIdle;
            run_d   = '0;
          end else if (dec_idx == cand_q) begin
            if (run_q + RunBits'(1) == RunBits'(CONFIRM_COUNT)) begin
              confirm = 1'b1;
              run_d   = '0;
              state_d = AfterConfirm;
              hold_d  = HoldBits'(HOLDOFF_RESULTS);
            end else begin
              run_d = run_q + RunBits'(1);
            end
          end else begin
            cand_d = dec_idx;
            run_d  = RunBits'(1);
          end
        end
        StHoldoff: begin
          // The result that brings the counter to zero is itself ignored.
          if (hold_q <= HoldBits'(1)) begin
            hold_d  = '0;
            state_d = StIdle;
          end else begin
            hold_d = hold_q - HoldBits'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------
  // Push staging register (one cycle between confirmation and FIFO write)
  // ---------------------------------------------------------------------------------------
  logic                   push_q;
  logic [KW_IDX_BITS-1:0] push_kw_q;
  logic [TS_BITS-1:0]     push_ts_q;

  // Capture the confirmed event with the pre-increment timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q    <= 1'b0;
      push_kw_q <= '0;
      push_ts_q <= '0;
    end else begin
      push_q <= confirm;
      if (confirm) begin
        push_kw_q <= dec_idx;
        push_ts_q <= ts_q;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------------------
  logic [KW_IDX_BITS-1:0] kw_mem [FIFO_DEPTH];
  logic [TS_BITS-1:0]     ts_mem [FIFO_DEPTH];
  logic [PtrBits-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LvlBits-1:0]     level_q, level_d;
  logic                   full, pop, wr_en, drop;
  logic                   overflow_q;

  // Handshake decode; a pop into an empty FIFO never happens since evt_valid is low.
  always_comb begin
    full  = (level_q == LvlBits'(FIFO_DEPTH));
    pop   = (level_q != '0) && evt_ready;
    wr_en = push_q && (!full || pop);
    drop  = push_q && full && !pop;
    level_d = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LvlBits'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - LvlBits'(1);
    end
  end

  // Storage, pointers and level; storage is reset so outputs read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        kw_mem[i] <= '0;
        ts_mem[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) begin
        kw_mem[wr_ptr_q] <= push_kw_q;
        ts_mem[wr_ptr_q] <= push_ts_q;
        wr_ptr_q         <= wr_ptr_q + PtrBits'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrBits'(1);
      end
      level_q <= level_d;
    end
  end

  // Sticky overflow; a drop in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef KWS_MULTI_HIT_REJECT_EN
  logic [7:0] mh_q;

  // Saturating count of rejected multi-bit results; a clear restarts from this cycle's hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh_q <= '0;
    end else if (clear_overflow) begin
      mh_q <= (kws_valid && multi) ? 8'd1 : 8'd0;
    end else if (kws_valid && multi && (mh_q != 8'hFF)) begin
      mh_q <= mh_q + 8'd1;
    end
  end

  assign multi_hit_count = mh_q;
`endif

  assign evt_valid     = (level_q != '0);
  assign irq           = evt_valid;
  assign evt_keyword   = kw_mem[rd_ptr_q];
  assign evt_timestamp = ts_mem[rd_ptr_q];
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_kws_event_reporter.sv
// Directed self-checking bench for kws_event_reporter (default parameters).
module tb_kws_event_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  kws_result = '0;
  logic        kws_valid = 1'b0;
  logic        enable = 1'b1;
  logic        evt_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        evt_valid;
  logic [3:0]  evt_keyword;
  logic [15:0] evt_timestamp;
  logic [2:0]  fifo_level;
  logic        irq;
  logic        overflow;
`ifdef KWS_MULTI_HIT_REJECT_EN
  logic [7:0]  multi_hit_count;
`endif

  int errors = 0;
  int checks = 0;

  kws_event_reporter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .kws_result     (kws_result),
    .kws_valid      (kws_valid),
    .enable         (enable),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_keyword    (evt_keyword),
    .evt_timestamp  (evt_timestamp),
    .fifo_level     (fifo_level),
    .irq            (irq),
    .overflow       (overflow),
`ifdef KWS_MULTI_HIT_REJECT_EN
    .multi_hit_count(multi_hit_count),
`endif
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One result strobe, driven and released on falling edges.
  task automatic send(input logic [9:0] r);
    @(negedge clk);
    kws_result = r;
    kws_valid  = 1'b1;
    @(negedge clk);
    kws_valid  = 1'b0;
    kws_result = '0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_evt_valid", evt_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_keyword", evt_keyword, 0);
    check("rst_timestamp", evt_timestamp, 0);

    // Basic confirmation: 0x004 x3 on ts 0..2
    repeat (3) send(10'h004);
    check("t1_valid_n1", evt_valid, 0);
    @(negedge clk);
    check("t1_valid_n2", evt_valid, 1);
    check("t1_irq", irq, 1);
    check("t1_level", fifo_level, 1);
    check("t1_keyword", evt_keyword, 2);
    check("t1_timestamp", evt_timestamp, 2);
    pop_one();
    check("t1_level_after_pop", fifo_level, 0);
    check("t1_irq_after_pop", irq, 0);

    // Candidate switch: 2,2,4,4,4 -> keyword 4 at ts 4
    do_reset();
    send(10'h004);
    send(10'h004);
    repeat (3) send(10'h010);
    @(negedge clk);
    check("t2_level", fifo_level, 1);
    check("t2_keyword", evt_keyword, 4);
    check("t2_timestamp", evt_timestamp, 4);
    pop_one();
    check("t2_level_after_pop", fifo_level, 0);

    // Hold-off: 8 results ignored, results 9..11 confirm keyword 1 at ts 15
    repeat (8) send(10'h002);
    repeat (2) @(negedge clk);
    check("t3_holdoff_level", fifo_level, 0);
    repeat (3) send(10'h002);
    @(negedge clk);
    check("t3_level", fifo_level, 1);
    check("t3_keyword", evt_keyword, 1);
    check("t3_timestamp", evt_timestamp, 15);
    pop_one();

    // Overflow: 5 confirmations into a 4-deep FIFO, consumer stalled
    do_reset();
    for (int j = 0; j < 5; j++) begin
      repeat (3) send(10'(1 << j));
      repeat (8) send(10'h000);
    end
    repeat (2) @(negedge clk);
    check("t4_level_full", fifo_level, 4);
    check("t4_overflow", overflow, 1);
    check("t4_head_stable_kw", evt_keyword, 0);
    for (int j = 0; j < 4; j++) begin
      check("t4_drain_valid", evt_valid, 1);
      check("t4_drain_kw", evt_keyword, j);
      check("t4_drain_ts", evt_timestamp, 11 * j + 2);
      pop_one();
    end
    check("t4_level_empty", fifo_level, 0);
    check("t4_overflow_sticky", overflow, 1);
    @(negedge clk);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    check("t4_overflow_cleared", overflow, 0);

    // Enable drop restarts the run
    do_reset();
    send(10'h008);
    send(10'h008);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    send(10'h008);
    repeat (3) @(negedge clk);
    check("t5_no_event", fifo_level, 0);
    send(10'h008);
    send(10'h008);
    @(negedge clk);
    check("t5_level", fifo_level, 1);
    check("t5_keyword", evt_keyword, 3);
    check("t5_timestamp", evt_timestamp, 4);

    // Reset discards queued events
    do_reset();
    check("t6_reset_level", fifo_level, 0);
    check("t6_reset_valid", evt_valid, 0);

`ifdef KWS_MULTI_HIT_REJECT_EN
    send(10'h005);
    check("t6_mh_count1", multi_hit_count, 1);
    send(10'h005);
    send(10'h005);
    repeat (2) @(negedge clk);
    check("t6_mh_no_event", fifo_level, 0);
    check("t6_mh_count3", multi_hit_count, 3);
    @(negedge clk);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    check("t6_mh_cleared", multi_hit_count, 0);
`else
    repeat (3) send(10'h005);
    @(negedge clk);
    check("t6_multi_level", fifo_level, 1);
    check("t6_multi_keyword", evt_keyword, 0);
    check("t6_multi_timestamp", evt_timestamp, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
